// File: rtl/mult_pkg.sv
// Shared definitions for the serial shift-add multiplier controller:
// FSM encoding, default operand width and operand byte-phase constants.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] PH_A_LO = 2'd0;
  localparam logic [1:0] PH_A_HI = 2'd1;
  localparam logic [1:0] PH_B_LO = 2'd2;
  localparam logic [1:0] PH_B_HI = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_PREP    = 3'd2,
    S_RUN     = 3'd3,
    S_FIX     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add multiplier datapath: one multiplier bit per step, with an
// in-place two's-complement negation of the packed {acc, multiplier} result.
module shift_add_dp #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fix_neg,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               last,
  output logic [2*WIDTH:0]   result
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum = acc;
    if (mplier[0]) begin
      sum = acc + {1'b0, mcand};
    end else begin
      sum = acc;
    end
  end

  // acc[WIDTH] is always 0 after a shift, so {acc, mplier} is {0, product} once RUN ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= CW'(WIDTH - 1);
    end else if (step) begin
      acc    <= {1'b0, sum[WIDTH:1]};
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt - CW'(1);
    end else if (fix_neg) begin
      {acc, mplier} <= -{acc, mplier};
    end
  end

  assign last   = (cnt == '0);
  assign result = {acc, mplier};

endmodule

// File: rtl/mult_sequencer.sv
// Operand capture from the byte-wide switch bus, multiply sequencing and
// registered result hand-off (data_out/set) to the display formatter.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl,
  input  logic [7:0]                    data_in,
  input  logic                          signed_mode,
  output logic [2*WIDTH:0]              data_out,
  output logic                          set,
  output logic                          busy,
  output logic [$clog2(WIDTH/4)-1:0]    phase
);

  localparam int NBYTES = WIDTH / 4;
  localparam int PW     = $clog2(NBYTES);
  localparam logic [PW-1:0] PH_LAST = PW'(NBYTES - 1);

  state_t state;
  state_t state_nx;

  logic               ctrl_q;
  logic               ctrl_ev;
  logic               cap_en;
  logic               cap_last;
  logic [2*WIDTH-1:0] ops;
  logic               sgn;
  logic               neg;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               load;
  logic               step;
  logic               fix_neg;
  logic               last;
  logic [2*WIDTH:0]   result;

  assign ctrl_ev = ctrl & ~ctrl_q;
  assign opa     = ops[WIDTH-1:0];
  assign opb     = ops[2*WIDTH-1:WIDTH];

  // Unsigned negation maps the most negative value onto its own magnitude
  always_comb begin
    mag_a = opa;
    mag_b = opb;
    if (sgn && opa[WIDTH-1]) begin
      mag_a = -opa;
    end else begin
      mag_a = opa;
    end
    if (sgn && opb[WIDTH-1]) begin
      mag_b = -opb;
    end else begin
      mag_b = opb;
    end
  end

  always_comb begin
    state_nx = state;
    cap_en   = 1'b0;
    cap_last = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    fix_neg  = 1'b0;
    case (state)
      S_IDLE, S_CAPTURE: begin
        if (ctrl_ev) begin
          cap_en = 1'b1;
          if (phase == PH_LAST) begin
            cap_last = 1'b1;
            state_nx = S_PREP;
          end else begin
            state_nx = S_CAPTURE;
          end
        end else begin
          state_nx = state;
        end
      end
      S_PREP: begin
        load     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_nx = S_FIX;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_FIX: begin
        fix_neg  = neg;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      ctrl_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ctrl_q <= ctrl;
    end
  end

  // Operand bytes, capture phase and the mode/sign flags for the pending multiply
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops   <= '0;
      phase <= PW'(PH_A_LO);
      sgn   <= 1'b0;
      neg   <= 1'b0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (cap_en && (phase == PW'(i))) begin
          ops[i*8 +: 8] <= data_in;
        end
      end
      if (cap_last) begin
        phase <= PW'(PH_A_LO);
        sgn   <= signed_mode;
      end else if (cap_en) begin
        phase <= phase + PW'(1);
      end
      if (load) begin
        neg <= sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      set      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      set <= (state == S_DONE);
      if (state == S_DONE) begin
        data_out <= result;
      end
      if (cap_last) begin
        busy <= 1'b1;
      end else if (set) begin
        busy <= 1'b0;
      end
    end
  end

  shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .fix_neg   (fix_neg),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .last      (last),
    .result    (result)
  );

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases plus random
// operands, compared against an integer-arithmetic product model.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl;
  logic [7:0]  data_in;
  logic        signed_mode;
  logic [32:0] data_out;
  logic        set;
  logic        busy;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl        (ctrl),
    .data_in     (data_in),
    .signed_mode (signed_mode),
    .data_out    (data_out),
    .set         (set),
    .busy        (busy),
    .phase       (phase)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_product(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint av;
    longint bv;
    longint p;
    av = longint'(a);
    bv = longint'(b);
    if (sm && a >= 16'h8000) av = av - 65536;
    if (sm && b >= 16'h8000) bv = bv - 65536;
    p = av * bv;
    return p[32:0];
  endfunction

  task automatic press(input logic [7:0] b);
    data_in = b;
    ctrl = 1'b1;
    @(posedge clk); #1;
    ctrl = 1'b0;
  endtask

  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          input bit poke, input int abort_at);
    logic [32:0] exp;
    logic [7:0]  bts [4];
    int set_at;
    int busy_cnt;
    int set_cnt;
    exp = ref_product(a, b, sm);
    bts[0] = a[7:0];
    bts[1] = a[15:8];
    bts[2] = b[7:0];
    bts[3] = b[15:8];
    signed_mode = sm;
    for (int i = 0; i < 4; i++) begin
      press(bts[i]);
      if (i < 3) begin
        check_eq("phase_step", 64'(phase), 64'(i + 1));
        @(posedge clk); #1;
      end
    end
    check_eq("busy_rise", 64'(busy), 64'd1);
    check_eq("phase_wrap", 64'(phase), 64'd0);
    set_at   = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40 && set_at < 0; k++) begin
      if (poke) ctrl = (k == 3 || k == 5 || k == 7);
      @(posedge clk); #1;
      if (abort_at == k) begin
        rst = 1'b0;
        #2;
        check_eq("abort_data_out", 64'(data_out), 64'd0);
        check_eq("abort_set", 64'(set), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_phase", 64'(phase), 64'd0);
        set_cnt = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (set) set_cnt++;
        end
        rst = 1'b1;
        repeat (25) begin
          @(posedge clk); #1;
          if (set) set_cnt++;
        end
        check_eq("abort_no_set", 64'(set_cnt), 64'd0);
        return;
      end
      if (busy) busy_cnt++;
      if (set) set_at = k;
    end
    ctrl = 1'b0;
    check_eq("set_latency", 64'(set_at), 64'd19);
    check_eq("product", 64'(data_out), 64'(exp));
    check_eq("busy_span", 64'(busy_cnt), 64'd19);
    @(posedge clk); #1;
    check_eq("set_pulse_width", 64'(set), 64'd0);
    check_eq("busy_fall", 64'(busy), 64'd0);
    check_eq("data_out_hold", 64'(data_out), 64'(exp));
    check_eq("phase_after", 64'(phase), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    ctrl = 1'b0;
    data_in = 8'h00;
    signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_data_out", 64'(data_out), 64'd0);
    check_eq("reset_set", 64'(set), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_phase", 64'(phase), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_mult(16'h0003, 16'h0005, 1'b0, 1'b0, 0);
    check_eq("unsigned_small_const", 64'(data_out), 64'h00000000F);
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
    check_eq("unsigned_max_const", 64'(data_out), 64'h0FFFE0001);
    run_mult(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
    check_eq("signed_minmin_const", 64'(data_out), 64'h040000000);
    run_mult(16'hFFFB, 16'h0007, 1'b1, 1'b0, 0);
    check_eq("signed_neg_const", 64'(data_out), 64'h1FFFFFFDD);
    run_mult(16'hFFFB, 16'h0000, 1'b1, 1'b1, 0);
    check_eq("signed_negzero_const", 64'(data_out), 64'd0);

    for (int r = 0; r < 10; r++) begin
      run_mult(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0, 0);
    end

    data_in = 8'h12;
    ctrl = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    ctrl = 1'b0;
    check_eq("hold_one_event", 64'(phase), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("partial_persists", 64'(phase), 64'd1);
    rst = 1'b0;
    #2;
    check_eq("partial_cleared", 64'(phase), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_mult(16'h1234, 16'h5678, 1'b0, 1'b0, 8);
    run_mult(16'h8001, 16'h7FFF, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
